// File: rtl/float_max_reduce.sv
//------------------------------------------------------------------------------
// float_max_reduce
//
// Versat functional unit computing a running and a windowed maximum over a
// stream of IEEE-754 binary32 values.
//
// After a one-cycle `run` pulse the unit waits `delay0` cycles and then takes
// one sample of `in0` on every cycle. Samples are grouped into windows of
// `amount` samples. A window length of 0 means the window never closes.
//
// Ports:
//   clk      - clock
//   rst      - synchronous, active-high reset
//   running  - accelerator running; low forces IDLE and out0 to 0
//   run      - one-cycle start pulse; loads delay0 and restarts the reduction
//   in0      - input float stream (one sample per cycle while accumulating)
//   delay0   - cycles to wait after run before the first sample
//   amount   - window length in samples (0 = unbounded)
//   out0     - running max of the current window (one cycle latency)
//   out1     - max of the last completed window, held until the next closes
//   done     - one-cycle pulse in the cycle out1 updates
//
// Optional feature macro: FLOAT_MAX_NAN_PROPAGATE_EN
//   Undefined (default): NaN samples are skipped; an all-NaN window closes
//                        with -inf.
//   Defined:             any NaN in a window makes out0 and the closing out1
//                        read as the canonical quiet NaN 32'h7FC0_0000.
//------------------------------------------------------------------------------
module float_max_reduce #(
  parameter int DELAY_W = 32,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic               run,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [31:0]        amount,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  output logic               done
);

  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACC  = 2'd2
  } state_t;

  // Monotonic ordering key: larger unsigned key means larger float.
  // Negative values have all bits flipped so larger magnitude sorts lower;
  // positive values get the top bit set so they sort above every negative.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Keeps the current value on a tie.
  function automatic logic [31:0] fmax_keep(input logic [31:0] cur,
                                            input logic [31:0] x);
    return (order_key(x) > order_key(cur)) ? x : cur;
  endfunction

  state_t             state_q,   state_d;
  logic [DELAY_W-1:0] delay_q,   delay_d;
  logic [31:0]        count_q,   count_d;
  logic [31:0]        cur_max_q, cur_max_d;
  logic [31:0]        out1_q,    out1_d;
  logic               done_q,    done_d;
  logic               sample_nan_s;
  logic               window_close_s;
`ifdef FLOAT_MAX_NAN_PROPAGATE_EN
  logic               nan_seen_q, nan_seen_d;
`endif

  // Next-state computation for the control FSM and reduction datapath.
  always_comb begin
    state_d        = state_q;
    delay_d        = delay_q;
    count_d        = count_q;
    cur_max_d      = cur_max_q;
    out1_d         = out1_q;
    done_d         = 1'b0;
    sample_nan_s   = is_nan(in0);
    window_close_s = (amount != 32'd0) &&
                     (({1'b0, count_q} + 33'd1) == {1'b0, amount});
`ifdef FLOAT_MAX_NAN_PROPAGATE_EN
    nan_seen_d     = nan_seen_q;
`endif

    if (!running) begin
      state_d = ST_IDLE;
    end else if (run) begin
      delay_d   = delay0;
      count_d   = 32'd0;
      cur_max_d = 32'd0;
`ifdef FLOAT_MAX_NAN_PROPAGATE_EN
      nan_seen_d = 1'b0;
`endif
      // A zero delay skips WAIT so the first sample is the next cycle.
      state_d   = (delay0 == '0) ? ST_ACC : ST_WAIT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_WAIT: begin
          delay_d = delay_q - DELAY_W'(1);
          if (delay_q <= DELAY_W'(1)) begin
            state_d = ST_ACC;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_ACC: begin
          // A NaN opening a window seeds -inf: every real sample compares
          // >= -inf, so this is equivalent to skipping it, and an all-NaN
          // window naturally closes with -inf.
          if (count_q == 32'd0) begin
            cur_max_d = sample_nan_s ? NEG_INF : in0;
          end else if (sample_nan_s) begin
            cur_max_d = cur_max_q;
          end else begin
            cur_max_d = fmax_keep(cur_max_q, in0);
          end
`ifdef FLOAT_MAX_NAN_PROPAGATE_EN
          nan_seen_d = ((count_q == 32'd0) ? 1'b0 : nan_seen_q) | sample_nan_s;
`endif
          if (window_close_s) begin
`ifdef FLOAT_MAX_NAN_PROPAGATE_EN
            out1_d = nan_seen_d ? QNAN : cur_max_d;
`else
            out1_d = cur_max_d;
`endif
            done_d  = 1'b1;
            count_d = 32'd0;
          end else if (count_q != 32'hFFFF_FFFF) begin
            count_d = count_q + 32'd1;
          end else begin
            count_d = count_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      delay_q   <= '0;
      count_q   <= 32'd0;
      cur_max_q <= 32'd0;
      out1_q    <= 32'd0;
      done_q    <= 1'b0;
`ifdef FLOAT_MAX_NAN_PROPAGATE_EN
      nan_seen_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      count_q   <= count_d;
      cur_max_q <= cur_max_d;
      out1_q    <= out1_d;
      done_q    <= done_d;
`ifdef FLOAT_MAX_NAN_PROPAGATE_EN
      nan_seen_q <= nan_seen_d;
`endif
    end
  end

  // out0 is gated by the live running input so it drops to 0 immediately.
`ifdef FLOAT_MAX_NAN_PROPAGATE_EN
  assign out0 = (running && (state_q == ST_ACC)) ?
                (nan_seen_q ? QNAN : cur_max_q) : 32'd0;
`else
  assign out0 = (running && (state_q == ST_ACC)) ? cur_max_q : 32'd0;
`endif
  assign out1 = out1_q;
  assign done = done_q;

endmodule

// File: tb/tb_float_max_reduce.sv
module tb_float_max_reduce;

  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        running = 1'b0;
  logic        run = 1'b0;
  logic [31:0] in0 = 32'd0;
  logic [31:0] delay0 = 32'd0;
  logic [31:0] amount = 32'd0;
  logic [31:0] out0;
  logic [31:0] out1;
  logic        done;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;

  float_max_reduce #(.DELAY_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run), .in0(in0),
    .delay0(delay0), .amount(amount), .out0(out0), .out1(out1), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] win[$];       // samples of the open window
  bit          m_active = 1'b0;
  longint      m_rem = 0;    // edges left until sampling (1 = sampling)
  int          m_nsamp = 0;  // samples since last run
  logic [31:0] m_cur = 32'd0;
  bit          m_cur_known = 1'b0;
  bit          m_cur_nan = 1'b0;
  logic [31:0] m_out1 = 32'd0;
  bit          m_done = 1'b0;

  function automatic bit f_isnan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Sign-magnitude float comparison a > b (non-NaN), with +0 > -0.
  function automatic bit f_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  task automatic summarize(output logic [31:0] mx, output bit valid, output bit anynan);
    mx = NEG_INF; valid = 1'b0; anynan = 1'b0;
    foreach (win[i]) begin
      if (f_isnan(win[i])) anynan = 1'b1;
      else if (!valid || f_gt(win[i], mx)) begin mx = win[i]; valid = 1'b1; end
    end
  endtask

  task automatic model_edge();
    logic [31:0] mx; bit valid; bit anynan;
    if (rst) begin
      m_active = 1'b0; win.delete(); m_out1 = 32'd0; m_done = 1'b0;
      m_nsamp = 0; m_cur_known = 1'b0; m_cur_nan = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!running) begin
        m_active = 1'b0;
      end else if (run) begin
        m_active = 1'b1; m_rem = longint'(delay0) + 1; win.delete();
        m_nsamp = 0; m_cur_known = 1'b0; m_cur_nan = 1'b0;
      end else if (m_active) begin
        if (m_rem > 1) m_rem--;
        else begin
          win.push_back(in0);
          m_nsamp++;
          summarize(mx, valid, anynan);
          m_cur = mx; m_cur_known = valid; m_cur_nan = anynan;
          if (amount != 32'd0 && win.size() == int'(amount)) begin
`ifdef FLOAT_MAX_NAN_PROPAGATE_EN
            m_out1 = anynan ? QNAN : (valid ? mx : NEG_INF);
`else
            m_out1 = valid ? mx : NEG_INF;
`endif
            m_done = 1'b1;
            win.delete();
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_model();
    bit known;
    if (!(m_active && m_rem == 1)) chk("out0_idle", out0, 32'd0);
    else begin
`ifdef FLOAT_MAX_NAN_PROPAGATE_EN
      known = (m_nsamp > 0) && (m_cur_known || m_cur_nan);
      if (known) chk("out0_run", out0, m_cur_nan ? QNAN : m_cur);
`else
      known = (m_nsamp > 0) && m_cur_known;
      if (known) chk("out0_run", out0, m_cur);
`endif
    end
    chk("out1", out1, m_out1);
    chk("done", {31'd0, done}, {31'd0, m_done});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_model();
  endtask

  function automatic logic [31:0] rand_float();
    logic [31:0] x;
    logic [31:0] tbl [4];
    tbl[0] = 32'h3F800000; tbl[1] = 32'hBF800000; tbl[2] = 32'h40000000; tbl[3] = 32'hC0000000;
    case ($urandom_range(0, 9))
      0: x = 32'h0000_0000;
      1: x = 32'h8000_0000;
      2: x = 32'h7F80_0000;
      3: x = 32'hFF80_0000;
      4: x = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom) | 23'd1};
      5: x = tbl[$urandom_range(0, 3)];
      default: begin
        x = $urandom;
        if (x[30:23] == 8'hFF) x[30:23] = 8'h80;
      end
    endcase
    return x;
  endfunction

  task automatic start_run(input int d, input int a);
    running = 1'b1; run = 1'b1; delay0 = 32'(d); amount = 32'(a); in0 = rand_float();
    tick();
    run = 1'b0;
    repeat (d) begin in0 = rand_float(); tick(); end
  endtask

  task automatic sample(input logic [31:0] x);
    in0 = x; tick();
  endtask

  logic [31:0] prev_out1;

  initial begin
    // reset
    rst = 1'b1; tick();
    chk("rst_out0", out0, 32'd0);
    chk("rst_out1", out1, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    // delay and latency
    start_run(3, 4);
    sample(32'h3F800000); chk("t1_out0_a", out0, 32'h3F800000);
    sample(32'hC0000000); chk("t1_out0_b", out0, 32'h3F800000);
    sample(32'h40B00000); chk("t1_out0_c", out0, 32'h40B00000); chk("t1_nodone", {31'd0, done}, 32'd0);
    sample(32'h3F000000); chk("t1_out0_d", out0, 32'h40B00000);
    chk("t1_done", {31'd0, done}, 32'd1); chk("t1_out1", out1, 32'h40B00000);

    // back-to-back windows
    start_run(0, 2);
    sample(32'hBF800000);
    sample(32'hC0400000); chk("t2_done1", {31'd0, done}, 32'd1); chk("t2_out1a", out1, 32'hBF800000);
    sample(32'hBF000000); chk("t2_gap", {31'd0, done}, 32'd0);
    sample(32'hC1000000); chk("t2_done2", {31'd0, done}, 32'd1); chk("t2_out1b", out1, 32'hBF000000);

    // signed zero and infinity ordering
    start_run(1, 2);
    sample(32'h80000000); sample(32'h00000000); chk("t3_zero", out1, 32'h00000000);
    sample(32'hFF800000); sample(32'hC2C80000); chk("t3_inf", out1, 32'hC2C80000);

    // NaN handling
    start_run(0, 3);
    sample(32'h40000000); sample(32'h7FC00001); sample(32'h3F800000);
`ifdef FLOAT_MAX_NAN_PROPAGATE_EN
    chk("t4_nan_win", out1, QNAN);
`else
    chk("t4_nan_win", out1, 32'h40000000);
`endif
    start_run(0, 2);
    sample(32'h7FC00001); sample(32'hFFC00000);
`ifdef FLOAT_MAX_NAN_PROPAGATE_EN
    chk("t4_all_nan", out1, QNAN);
`else
    chk("t4_all_nan", out1, NEG_INF);
`endif
    prev_out1 = m_out1;

    // abort by dropping running
    start_run(0, 4);
    sample(32'h41200000); sample(32'h41A00000);
    running = 1'b0; tick();
    chk("t5_drop_done", {31'd0, done}, 32'd0);
    chk("t5_drop_out1", out1, prev_out1);
    chk("t5_drop_out0", out0, 32'd0);
    tick();
    // abort by a fresh run
    start_run(0, 4);
    sample(32'h41200000); sample(32'h41A00000);
    start_run(0, 4);
    chk("t5_rerun_done", {31'd0, done}, 32'd0);
    chk("t5_rerun_out1", out1, prev_out1);
    sample(32'h3F800000);
    // reset mid-window
    rst = 1'b1; tick();
    chk("t5_rst_out0", out0, 32'd0);
    chk("t5_rst_out1", out1, 32'd0);
    chk("t5_rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    // unbounded window
    start_run(2, 0);
    for (int i = 0; i < 1000; i++) sample(32'h3F800000 + 32'(i));
    chk("t6_out0_last", out0, 32'h3F800000 + 32'd999);
    chk("t6_nodone", {31'd0, done}, 32'd0);

    // randomized episodes
    for (int e = 0; e < 250; e++) begin
      if ($urandom_range(0, 15) == 0) begin rst = 1'b1; tick(); rst = 1'b0; end
      start_run($urandom_range(0, 5), $urandom_range(0, 6));
      for (int k = 0, n = $urandom_range(0, 25); k < n; k++) begin
        if ($urandom_range(0, 29) == 0) running = 1'b0;
        in0 = rand_float();
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
